// File: rtl/wm_lsb_embed.sv
`default_nettype none
// ============================================================================
//  Module   : wm_lsb_embed
//  Purpose  : Watermark embedder ahead of the image writer. Replaces the LSB
//             of each colour byte of an RGB888 pixel pair with six bits of a
//             serially preloaded payload, rotating the payload by 6 per pair.
//  Option   : WM_CHECKSUM_EN adds a 16-bit running sum of the output bytes.
//  Revision : 1.0  initial release
// ============================================================================
module wm_lsb_embed #(
    parameter int WIDTH  = 8,
    parameter int HEIGHT = 8,
    parameter int WM_LEN = 48
) (
    input  logic        HCLK,
    input  logic        HRESET,
    input  logic        wm_load,
    input  logic        wm_bit,
    input  logic        start,
    input  logic        in_valid,
    input  logic [7:0]  DATA_R0,
    input  logic [7:0]  DATA_G0,
    input  logic [7:0]  DATA_B0,
    input  logic [7:0]  DATA_R1,
    input  logic [7:0]  DATA_G1,
    input  logic [7:0]  DATA_B1,
    output logic        hsync,
    output logic [7:0]  DATA_WRITE_R0,
    output logic [7:0]  DATA_WRITE_G0,
    output logic [7:0]  DATA_WRITE_B0,
    output logic [7:0]  DATA_WRITE_R1,
    output logic [7:0]  DATA_WRITE_G1,
    output logic [7:0]  DATA_WRITE_B1,
    output logic        busy,
`ifdef WM_CHECKSUM_EN
    output logic [15:0] checksum,
`endif
    output logic        frame_done
);

    localparam int NPAIRS = WIDTH * HEIGHT / 2;
    localparam int CW     = $clog2(NPAIRS + 1);
    localparam logic [CW-1:0] c_npairs = CW'(NPAIRS);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_LOADED = 2'd1,
        S_EMBED  = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    state_t              r_state;
    state_t              w_next;
    logic [WM_LEN-1:0]   r_wm;
    logic [WM_LEN-1:0]   w_rot;
    logic [CW-1:0]       r_cnt;
    logic                w_accept;
    logic                w_shift;
    logic [7:0]          w_r0, w_g0, w_b0, w_r1, w_g1, w_b1;
    logic                w_unused;

    // The original LSBs are overwritten, so they never reach the output.
    assign w_unused = &{DATA_R0[0], DATA_G0[0], DATA_B0[0],
                        DATA_R1[0], DATA_G1[0], DATA_B1[0]};

    // A pair is only taken while embedding and before the frame is complete.
    assign w_accept = (r_state == S_EMBED) && in_valid && (r_cnt != c_npairs);
    assign w_shift  = ((r_state == S_IDLE) || (r_state == S_LOADED)) && wm_load;

    // Rotate-left by 6; with WM_LEN == 6 both shifts collapse to the identity.
    assign w_rot = (r_wm << 6) | (r_wm >> (WM_LEN - 6));

    assign w_r0 = {DATA_R0[7:1], r_wm[WM_LEN-1]};
    assign w_g0 = {DATA_G0[7:1], r_wm[WM_LEN-2]};
    assign w_b0 = {DATA_B0[7:1], r_wm[WM_LEN-3]};
    assign w_r1 = {DATA_R1[7:1], r_wm[WM_LEN-4]};
    assign w_g1 = {DATA_G1[7:1], r_wm[WM_LEN-5]};
    assign w_b1 = {DATA_B1[7:1], r_wm[WM_LEN-6]};

    // Next-state logic; a load in the same cycle as start takes priority.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   if (wm_load) w_next = S_LOADED;
            S_LOADED: if (start && !wm_load) w_next = S_EMBED;
            S_EMBED:  if (r_cnt == c_npairs) w_next = S_DONE;
            S_DONE:   w_next = S_LOADED;
            default:  w_next = S_IDLE;
        endcase
    end

    // State register, pair counter and payload shift/rotate register.
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_wm    <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == S_DONE) begin
                r_cnt <= '0;
            end else if (w_accept) begin
                r_cnt <= r_cnt + CW'(1);
            end
            if (w_shift) begin
                r_wm <= {r_wm[WM_LEN-2:0], wm_bit};
            end else if (w_accept) begin
                r_wm <= w_rot;
            end
        end
    end

    // Registered outputs: data holds between pairs, status follows next state.
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            hsync         <= 1'b0;
            busy          <= 1'b0;
            frame_done    <= 1'b0;
            DATA_WRITE_R0 <= '0;
            DATA_WRITE_G0 <= '0;
            DATA_WRITE_B0 <= '0;
            DATA_WRITE_R1 <= '0;
            DATA_WRITE_G1 <= '0;
            DATA_WRITE_B1 <= '0;
        end else begin
            hsync      <= w_accept;
            busy       <= (w_next == S_EMBED);
            frame_done <= (w_next == S_DONE);
            if (w_accept) begin
                DATA_WRITE_R0 <= w_r0;
                DATA_WRITE_G0 <= w_g0;
                DATA_WRITE_B0 <= w_b0;
                DATA_WRITE_R1 <= w_r1;
                DATA_WRITE_G1 <= w_g1;
                DATA_WRITE_B1 <= w_b1;
            end
        end
    end

`ifdef WM_CHECKSUM_EN
    // Running sum of every emitted byte, restarted when a frame begins.
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            checksum <= '0;
        end else if ((r_state == S_LOADED) && (w_next == S_EMBED)) begin
            checksum <= '0;
        end else if (w_accept) begin
            checksum <= checksum + 16'(w_r0) + 16'(w_g0) + 16'(w_b0)
                                 + 16'(w_r1) + 16'(w_g1) + 16'(w_b1);
        end
    end
`endif

endmodule
`default_nettype wire
